// File: rtl/mem_port_ctrl_pkg.sv
// Shared types for the two-port memory controller.
//   state_t    : controller FSM states
//   owner_t    : which requester owns the current access
//   WORD_BEATS : byte beats needed to store one 32-bit word
//   beat_byte  : selects the big-endian byte written on a given store beat
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  typedef enum logic       {OWN_I, OWN_D}       owner_t;

  localparam int WORD_BEATS = 4;

  // Beat 0 writes the most significant byte to the lowest address.
  function automatic logic [7:0] beat_byte(input logic [31:0] w, input logic [1:0] beat);
    case (beat)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Bundle of the fetch port, data port and byte-wide memory port.
//   slave  : the controller (takes requests and read data, drives completions
//            and the memory address/write signals)
//   master : the environment (fetch unit, load/store unit and memory)
interface mem_port_ctrl_if #(parameter int AW = 32);
  // fetch requester
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_valid;
  logic [31:0]   i_rdata;
  // data requester
  logic          d_req;
  logic          d_we;
  logic          d_byte;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_valid;
  logic [31:0]   d_rdata;
  // memory
  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic          mem_byte_src;
  logic [7:0]    mem_wd;
  logic [31:0]   mem_rd;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rd,
    output i_valid, i_rdata, d_valid, d_rdata, mem_a, mem_we, mem_byte_src, mem_wd
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rd,
    input  i_valid, i_rdata, d_valid, d_rdata, mem_a, mem_we, mem_byte_src, mem_wd
  );
endinterface

// File: rtl/mem_port_ctrl_rr_arb2.sv
// Two-input round-robin arbiter.
//   req_i, req_d : fetch / data requests
//   last_served  : port that owned the previous access
//   gnt          : some port is granted
//   owner        : winning port (only meaningful when gnt=1)
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last_served,
  output logic   gnt,
  output owner_t owner
);

  assign gnt = req_i | req_d;

  // On a tie the port that was not served last wins.
  always_comb begin
    owner = OWN_D;
    if (req_i && req_d) owner = (last_served == OWN_D) ? OWN_I : OWN_D;
    else if (req_i)     owner = OWN_I;
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Shares one byte-write / word-read memory port between the fetch and data
// requesters. Reads take one access; word stores go out as four byte beats,
// most significant byte first at the lowest address.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch port, data port and memory port (slave side)
module mem_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_ctrl_if.slave bus
);

  state_t        state, state_n;
  logic [1:0]    beat, beat_n;
  owner_t        owner, last_served;
  logic [AW-1:0] addr_q;
  logic          byte_q;
  logic [31:0]   wdata_q;
  logic [31:0]   i_rdata_q, d_rdata_q;

  logic   gnt;
  owner_t win;

  logic [AW-1:0] mem_a;
  logic          mem_we, mem_byte_src;
  logic [7:0]    mem_wd;

  rr_arb2 u_arb (
    .req_i       (bus.i_req),
    .req_d       (bus.d_req),
    .last_served (last_served),
    .gnt         (gnt),
    .owner       (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat        <= 2'd0;
      owner       <= OWN_I;
      last_served <= OWN_D;
      addr_q      <= '0;
      byte_q      <= 1'b0;
      wdata_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
      if (state == IDLE && gnt) begin
        owner  <= win;
        addr_q <= (win == OWN_I) ? bus.i_addr : bus.d_addr;
        // fetch is always a word read
        byte_q <= (win == OWN_D) && bus.d_byte;
        if (win == OWN_D) wdata_q <= bus.d_wdata;
      end
      if (state == RD) begin
        if (owner == OWN_I) i_rdata_q <= bus.mem_rd;
        else                d_rdata_q <= bus.mem_rd;
      end
      if (state == RESP) last_served <= owner;
    end
  end

  // Memory signals decode only from registered state so no request input
  // reaches the memory port combinationally.
  always_comb begin
    state_n      = state;
    beat_n       = beat;
    mem_a        = '0;
    mem_we       = 1'b0;
    mem_byte_src = 1'b0;
    mem_wd       = 8'h00;
    case (state)
      IDLE: begin
        if (gnt) begin
          state_n = (win == OWN_D && bus.d_we) ? WR : RD;
          beat_n  = 2'd0;
        end
      end
      RD: begin
        mem_a        = addr_q;
        mem_byte_src = byte_q;
        state_n      = RESP;
      end
      WR: begin
        mem_we = 1'b1;
        mem_a  = addr_q + AW'(beat);
        mem_wd = byte_q ? wdata_q[7:0] : beat_byte(wdata_q, beat);
        if (byte_q || beat == 2'(WORD_BEATS - 1)) state_n = RESP;
        else                                      beat_n  = beat + 2'd1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.mem_a        = mem_a;
  assign bus.mem_we       = mem_we;
  assign bus.mem_byte_src = mem_byte_src;
  assign bus.mem_wd       = mem_wd;
  assign bus.i_valid      = (state == RESP) && (owner == OWN_I);
  assign bus.d_valid      = (state == RESP) && (owner == OWN_D);
  assign bus.i_rdata      = i_rdata_q;
  assign bus.d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: directed scenarios then randomized traffic,
// checked against a transaction-level model of arbitration, latency and
// byte-addressed memory contents.
module tb_mem_port_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_ctrl_if #(.AW(32)) bus();
  mem_port_ctrl #(.AW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // memory attached to the DUT (256 bytes, address bits above 7 ignored)
  logic [7:0] mem     [256];
  // model's view of what memory must contain
  logic [7:0] ref_mem [256];

  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[7:0]] <= bus.mem_wd;

  function automatic logic [31:0] rdw(input logic [7:0] b);
    logic [7:0] b1, b2, b3;
    b1 = b + 8'd1; b2 = b + 8'd2; b3 = b + 8'd3;
    return {mem[b], mem[b1], mem[b2], mem[b3]};
  endfunction

  function automatic logic [31:0] refw(input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = a[7:0]; b1 = b0 + 8'd1; b2 = b0 + 8'd2; b3 = b0 + 8'd3;
    return {ref_mem[b0], ref_mem[b1], ref_mem[b2], ref_mem[b3]};
  endfunction

  always_comb bus.mem_rd = bus.mem_byte_src ? {24'h0, mem[bus.mem_a[7:0]]} : rdw(bus.mem_a[7:0]);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // model state
  bit          ref_last_d = 1'b1;   // last served was data
  logic [31:0] ref_drd    = '0;

  // per-cycle log of the memory port during the latest transaction
  logic        log_we [32];
  logic        log_bs [32];
  logic [31:0] log_a  [32];
  logic [7:0]  log_wd [32];
  int          i_cyc, d_cyc;
  logic [31:0] i_got, d_got;

  // Starts at a negedge with the DUT about to be IDLE; that IDLE cycle is 0.
  task automatic run(input bit di, input logic [31:0] ia,
                     input bit dd, input bit we, input bit by,
                     input logic [31:0] da, input logic [31:0] wd, input string tag);
    bit          i_first;
    int          li, ld, exp_i, exp_d;
    logic [31:0] ei, ed, t;
    logic [7:0]  ix;
    @(negedge clk);
    li = 2;
    ld = (we && !by) ? 5 : 2;
    i_first = di && (!dd || ref_last_d);
    if (di && dd) begin
      if (i_first) begin exp_i = li; exp_d = li + 1 + ld; end
      else         begin exp_d = ld; exp_i = ld + 1 + li; end
    end else begin
      exp_i = li; exp_d = ld;
    end
    ei = '0; ed = ref_drd;
    if (di && i_first) ei = refw(ia);
    if (dd) begin
      if (!we) begin
        ed = by ? {24'h0, ref_mem[da[7:0]]} : refw(da);
        ref_drd = ed;
      end else if (by) begin
        ref_mem[da[7:0]] = wd[7:0];
      end else begin
        for (int k = 0; k < 4; k++) begin
          t  = wd >> (24 - 8 * k);
          ix = da[7:0] + 8'(k);
          ref_mem[ix] = t[7:0];
        end
      end
    end
    if (di && !i_first) ei = refw(ia);
    if (di && dd) ref_last_d = i_first;
    else if (di)  ref_last_d = 1'b0;
    else if (dd)  ref_last_d = 1'b1;

    bus.i_req = di; bus.i_addr = ia;
    bus.d_req = dd; bus.d_we = we; bus.d_byte = by; bus.d_addr = da; bus.d_wdata = wd;
    i_cyc = -1; d_cyc = -1; i_got = '0; d_got = '0;
    for (int c = 0; c < 32; c++) begin
      log_we[c] = 1'b0; log_bs[c] = 1'b0; log_a[c] = '0; log_wd[c] = '0;
    end
    for (int c = 1; c < 32; c++) begin
      @(negedge clk);
      log_we[c] = bus.mem_we; log_bs[c] = bus.mem_byte_src;
      log_a[c]  = bus.mem_a;  log_wd[c] = bus.mem_wd;
      if (bus.i_valid) begin
        if (i_cyc < 0) i_cyc = c;
        i_got = bus.i_rdata; bus.i_req = 1'b0;
      end
      if (bus.d_valid) begin
        if (d_cyc < 0) d_cyc = c;
        d_got = bus.d_rdata; bus.d_req = 1'b0;
      end
      if ((!di || i_cyc >= 0) && (!dd || d_cyc >= 0)) break;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    if (di) begin
      chk({tag, ".i_cyc"},   32'(i_cyc), 32'(exp_i));
      chk({tag, ".i_rdata"}, i_got, ei);
    end else chk({tag, ".i_spurious"}, 32'(i_cyc), 32'hFFFF_FFFF);
    if (dd) begin
      chk({tag, ".d_cyc"},   32'(d_cyc), 32'(exp_d));
      chk({tag, ".d_rdata"}, d_got, ed);
    end else chk({tag, ".d_spurious"}, 32'(d_cyc), 32'hFFFF_FFFF);
  endtask

  initial begin
    int          vcnt, mode;
    bit          di, dd, we, by;
    logic [31:0] ia, da, wd;

    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_byte = 0;
    bus.d_addr = '0; bus.d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end
    mem[8'h10] = 8'hDE; mem[8'h11] = 8'hAD; mem[8'h12] = 8'hBE; mem[8'h13] = 8'hEF;
    ref_mem[8'h10] = 8'hDE; ref_mem[8'h11] = 8'hAD; ref_mem[8'h12] = 8'hBE; ref_mem[8'h13] = 8'hEF;
    mem[8'h05] = 8'hA5; ref_mem[8'h05] = 8'hA5;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst.i_valid", 32'(bus.i_valid), 0);
    chk("rst.d_valid", 32'(bus.d_valid), 0);
    chk("rst.i_rdata", bus.i_rdata, 0);
    chk("rst.d_rdata", bus.d_rdata, 0);
    chk("rst.mem_we",  32'(bus.mem_we), 0);
    chk("rst.mem_a",   bus.mem_a, 0);
    chk("rst.mem_bs",  32'(bus.mem_byte_src), 0);
    chk("rst.mem_wd",  32'(bus.mem_wd), 0);
    rst_n = 1'b1;

    // tie from reset: fetch first, data byte load second
    run(1, 32'h10, 1, 0, 1, 32'h05, 32'h0, "tie1");
    chk("tie1.i_cyc_abs", 32'(i_cyc), 2);
    chk("tie1.d_cyc_abs", 32'(d_cyc), 5);
    chk("tie1.mem_a1",    log_a[1], 32'h10);
    chk("tie1.bs1",       32'(log_bs[1]), 0);
    chk("tie1.i_word",    i_got, 32'hDEADBEEF);
    chk("tie1.bs4",       32'(log_bs[4]), 1);
    chk("tie1.d_byte",    d_got, 32'h0000_00A5);

    // second tie: fetch wins again
    run(1, 32'h20, 1, 0, 0, 32'h10, 32'h0, "tie2");
    chk("tie2.i_first", 32'(i_cyc), 2);

    // word store 0x20
    run(0, 0, 1, 1, 0, 32'h20, 32'h11223344, "wst");
    for (int b = 0; b < 4; b++) begin
      chk("wst.we", 32'(log_we[b+1]), 1);
      chk("wst.a",  log_a[b+1], 32'h20 + 32'(b));
    end
    chk("wst.wd1", 32'(log_wd[1]), 32'h11);
    chk("wst.wd2", 32'(log_wd[2]), 32'h22);
    chk("wst.wd3", 32'(log_wd[3]), 32'h33);
    chk("wst.wd4", 32'(log_wd[4]), 32'h44);

    // byte load
    run(0, 0, 1, 0, 1, 32'h05, 32'h0, "bld");
    chk("bld.bs1", 32'(log_bs[1]), 1);
    chk("bld.val", d_got, 32'h0000_00A5);

    // byte store then read it back as a word
    run(0, 0, 1, 1, 1, 32'h21, 32'hFFFF_FF5A, "bst");
    chk("bst.wd1", 32'(log_wd[1]), 32'h5A);
    run(1, 32'h20, 0, 0, 0, 0, 0, "bst_rb");
    chk("bst_rb.val", i_got, 32'h115A3344);

    // address wrap
    run(0, 0, 1, 1, 0, 32'hFFFF_FFFE, 32'h55667788, "wrap");
    chk("wrap.a1", log_a[1], 32'hFFFF_FFFE);
    chk("wrap.a2", log_a[2], 32'hFFFF_FFFF);
    chk("wrap.a3", log_a[3], 32'h0000_0000);
    chk("wrap.a4", log_a[4], 32'h0000_0001);

    // reset during beat 2 of a word store
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 1; bus.d_byte = 0; bus.d_addr = 32'h40; bus.d_wdata = 32'hAABBCCDD;
    repeat (3) @(negedge clk);
    chk("mrst.pre_we", 32'(bus.mem_we), 1);
    chk("mrst.pre_a",  bus.mem_a, 32'h42);
    rst_n = 1'b0;
    #1;
    chk("mrst.we",      32'(bus.mem_we), 0);
    chk("mrst.a",       bus.mem_a, 0);
    chk("mrst.d_valid", 32'(bus.d_valid), 0);
    bus.d_req = 0;
    vcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.d_valid || bus.i_valid) vcnt++;
    end
    chk("mrst.no_valid", 32'(vcnt), 0);
    chk("mrst.d_rdata",  bus.d_rdata, 0);
    rst_n = 1'b1;
    ref_mem[8'h40] = 8'hAA; ref_mem[8'h41] = 8'hBB;
    ref_last_d = 1'b1; ref_drd = '0;
    run(1, 32'h40, 0, 0, 0, 0, 0, "post_rst");

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      mode = $urandom_range(0, 2);
      di = (mode != 1);
      dd = (mode != 0);
      we = 1'($urandom_range(0, 1));
      by = 1'($urandom_range(0, 1));
      ia = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
      da = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
      wd = $urandom;
      run(di, ia, dd, we, by, da, wd, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
